// File: rtl/frag_rd_arbiter_if.sv
// frag_rd_arbiter_if: job control, memory read port and fragment FIFO push bundle
interface frag_rd_arbiter_if #(
  parameter int NUM_F_PIPES = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4,
  parameter int FREE_W = 8,
  parameter int FRAG_CNT_W = 16
);
  logic en;
  logic start;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] f_array_ptr;
  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize;
  logic [FRAG_CNT_W-1:0] num_frags;
  logic mem_rd_en;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [NUM_F_PIPES*FREE_W-1:0] frag_fifo_free;
  logic [NUM_F_PIPES-1:0] frag_fifo_wr_en;
  logic [DATA_WIDTH-1:0] frag_fifo_wr_data;
  logic frag_fifo_wr_last;
  logic busy;
  logic done;
  modport master (
    input en, start, f_array_ptr, vertexSize, num_frags, mem_rd_data, frag_fifo_free,
    output mem_rd_en, mem_rd_addr, frag_fifo_wr_en, frag_fifo_wr_data, frag_fifo_wr_last, busy, done
  );
  modport slave (
    output en, start, f_array_ptr, vertexSize, num_frags, mem_rd_data, frag_fifo_free,
    input mem_rd_en, mem_rd_addr, frag_fifo_wr_en, frag_fifo_wr_data, frag_fifo_wr_last, busy, done
  );
endinterface

// File: rtl/frag_rd_arbiter.sv
// frag_rd_arbiter: fetches packed fragments from memory and pushes each whole into a round-robin chosen FIFO
module frag_rd_arbiter #(
  parameter int NUM_F_PIPES = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4,
  parameter int FREE_W = 8,
  parameter int FRAG_CNT_W = 16
) (
  input logic clk,
  input logic resetn,
  frag_rd_arbiter_if.master bus
);
  localparam int PW = NUM_F_PIPES > 1 ? $clog2(NUM_F_PIPES) : 1;
  localparam int MAW = MAIN_MEM_ADDR_WIDTH;
  localparam int LVW = LOCAL_VERTEX_MEM_ADDR_WIDTH;
  localparam int FCW = FRAG_CNT_W;
  typedef enum logic [1:0] {IDLE, SELECT, READ, FINISH} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, sel_q, sel_d, seld_q, pick;
  logic [LVW-1:0] vsz_q, vsz_d, offs_q, offs_d;
  logic [MAW-1:0] base_q, base_d;
  logic [FCW-1:0] left_q, left_d;
  logic [FREE_W-1:0] need;
  logic vld_q, lastd_q, hit, issue, fin;
  always_comb begin
    need = FREE_W'(vsz_q) + FREE_W'(1);
    hit = 1'b0;
    pick = '0;
    for (int k = 0; k < NUM_F_PIPES; k++) begin
      if (!hit && bus.frag_fifo_free[((int'(rr_q) + k) % NUM_F_PIPES) * FREE_W +: FREE_W] >= need) begin
        hit = 1'b1;
        pick = PW'((int'(rr_q) + k) % NUM_F_PIPES);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    sel_d = sel_q;
    vsz_d = vsz_q;
    offs_d = offs_q;
    base_d = base_q;
    left_d = left_q;
    issue = bus.en && state_q == READ;
    fin = bus.en && state_q == FINISH && !vld_q;
    if (bus.en) begin
      case (state_q)
        IDLE: if (bus.start) begin
          vsz_d = bus.vertexSize;
          base_d = bus.f_array_ptr;
          left_d = bus.num_frags;
          state_d = bus.num_frags == '0 ? FINISH : SELECT;
        end
        SELECT: if (hit) begin
          sel_d = pick;
          offs_d = '0;
          state_d = READ;
        end
        READ: begin
          offs_d = offs_q + 1'b1;
          if (offs_q == vsz_q) begin
            base_d = base_q + MAW'(vsz_q) + MAW'(1);
            left_d = left_q - 1'b1;
            rr_d = PW'((int'(sel_q) + 1) % NUM_F_PIPES);
            state_d = left_q == FCW'(1) ? FINISH : SELECT;
          end
        end
        default: if (!vld_q) state_d = IDLE;
      endcase
    end
  end
  // return path: the word read last cycle is pushed to the pipe chosen when it was issued
  assign bus.mem_rd_en = issue;
  assign bus.mem_rd_addr = issue ? base_q + MAW'(offs_q) : '0;
  assign bus.frag_fifo_wr_en = vld_q ? NUM_F_PIPES'(1) << seld_q : '0;
  assign bus.frag_fifo_wr_data = vld_q ? bus.mem_rd_data : '0;
  assign bus.frag_fifo_wr_last = vld_q && lastd_q;
  assign bus.done = fin;
  assign bus.busy = state_q != IDLE && !fin;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rr_q <= '0;
      sel_q <= '0;
      vsz_q <= '0;
      offs_q <= '0;
      base_q <= '0;
      left_q <= '0;
      vld_q <= 1'b0;
      seld_q <= '0;
      lastd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      sel_q <= sel_d;
      vsz_q <= vsz_d;
      offs_q <= offs_d;
      base_q <= base_d;
      left_q <= left_d;
      vld_q <= issue;
      seld_q <= sel_q;
      lastd_q <= offs_q == vsz_q;
    end
  end
endmodule

// File: tb/tb_frag_rd_arbiter.sv
// tb_frag_rd_arbiter: word-count reference model with per-cycle compare, plus directed literal checks
module tb_frag_rd_arbiter;
  localparam int NP = 2;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int passed = 0;
  bit m_on = 1'b0;
  logic [31:0] rd_q[$];
  logic [1:0] last_q[$];
  always #5 clk = ~clk;
  frag_rd_arbiter_if #(.NUM_F_PIPES(NP)) b2();
  frag_rd_arbiter_if #(.NUM_F_PIPES(1)) b1();
  frag_rd_arbiter #(.NUM_F_PIPES(NP)) u2(.clk(clk), .resetn(resetn), .bus(b2));
  frag_rd_arbiter #(.NUM_F_PIPES(1)) u1(.clk(clk), .resetn(resetn), .bus(b1));
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic void chk(input string n, input longint unsigned a, input longint unsigned e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic r1, r2;
  logic [31:0] a1, a2;
  always @(negedge clk) begin
    r1 = b1.mem_rd_en; a1 = b1.mem_rd_addr;
    r2 = b2.mem_rd_en; a2 = b2.mem_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    b1.mem_rd_data = r1 ? f(a1) : $urandom;
    b2.mem_rd_data = r2 ? f(a2) : $urandom;
  end
  // reference: a job is a run of nf*(vsz+1) consecutive word reads from ptr, one pick cycle per fragment
  localparam int M_IDLE = 0, M_PICK = 1, M_READ = 2, M_DRAIN = 3;
  int m_ph = M_IDLE, m_L = 1, m_total = 0, m_issued = 0, m_pipe = 0, m_rr = 0;
  logic [31:0] m_ptr = '0;
  bit p_vld = 1'b0, p_last = 1'b0;
  int p_pipe = 0;
  logic [31:0] p_addr = '0;
  always @(negedge clk) begin
    bit e_rd, e_done, e_busy, e_last, found;
    logic [31:0] e_addr, e_data;
    logic [1:0] e_wr;
    e_wr = p_vld ? 2'(1 << p_pipe) : 2'b00;
    e_data = p_vld ? f(p_addr) : 32'h0;
    e_last = p_vld && p_last;
    e_rd = m_ph == M_READ && b2.en;
    e_addr = e_rd ? m_ptr + 32'(m_issued) : 32'h0;
    e_done = m_ph == M_DRAIN && !p_vld && b2.en;
    e_busy = m_ph != M_IDLE && !e_done;
    if (m_on) begin
      chk("rd_en", b2.mem_rd_en, e_rd);
      chk("rd_addr", b2.mem_rd_addr, e_addr);
      chk("wr_en", b2.frag_fifo_wr_en, e_wr);
      chk("wr_data", b2.frag_fifo_wr_data, e_data);
      chk("wr_last", b2.frag_fifo_wr_last, e_last);
      chk("busy", b2.busy, e_busy);
      chk("done", b2.done, e_done);
      if (b2.mem_rd_en) rd_q.push_back(b2.mem_rd_addr);
      if (b2.frag_fifo_wr_last) last_q.push_back(b2.frag_fifo_wr_en);
    end
    p_vld = e_rd;
    p_pipe = m_pipe;
    p_addr = e_addr;
    p_last = (m_issued % m_L) == m_L - 1;
    if (b2.en) begin
      if (m_ph == M_IDLE) begin
        if (b2.start) begin
          m_ptr = b2.f_array_ptr;
          m_L = int'(b2.vertexSize) + 1;
          m_total = int'(b2.num_frags) * m_L;
          m_issued = 0;
          m_ph = b2.num_frags == 0 ? M_DRAIN : M_PICK;
        end
      end else if (m_ph == M_PICK) begin
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          if (!found && int'(b2.frag_fifo_free[((m_rr + k) % NP) * 8 +: 8]) >= m_L) begin
            found = 1'b1;
            m_pipe = (m_rr + k) % NP;
            m_ph = M_READ;
          end
        end
      end else if (m_ph == M_READ) begin
        m_issued++;
        if (m_issued % m_L == 0) begin
          m_rr = (m_pipe + 1) % NP;
          m_ph = m_issued == m_total ? M_DRAIN : M_PICK;
        end
      end else if (e_done) m_ph = M_IDLE;
    end
    if (!resetn) begin
      m_ph = M_IDLE;
      m_rr = 0;
      p_vld = 1'b0;
    end
  end
  task automatic go(input logic [31:0] p, input logic [3:0] v, input logic [15:0] n);
    b2.f_array_ptr = p; b2.vertexSize = v; b2.num_frags = n; b2.start = 1'b1;
    cyc();
    b2.start = 1'b0;
  endtask
  task automatic wait_done(input bit rnd);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (b2.done) begin
        cyc();
        b2.start = 1'b0;
        b2.en = 1'b1;
        return;
      end
      cyc();
      b2.start = 1'b0;
      if (rnd) begin
        b2.en = $urandom_range(0, 7) != 0;
        if ($urandom_range(0, 3) == 0) b2.frag_fifo_free = {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
        if ($urandom_range(0, 15) == 0) begin
          b2.start = 1'b1; b2.f_array_ptr = $urandom; b2.vertexSize = 4'($urandom); b2.num_frags = 16'($urandom);
        end
      end
    end
    chk("done_timeout", 0, 1);
  endtask
  initial begin
    logic [13:0] mr, mw, ml, md;
    int n;
    b1.en = 1'b1; b1.start = 1'b0; b1.f_array_ptr = 32'h100; b1.vertexSize = 4'd3; b1.num_frags = 16'd2;
    b1.frag_fifo_free = 8'd16;
    b2.en = 1'b1; b2.start = 1'b0; b2.f_array_ptr = '0; b2.vertexSize = '0; b2.num_frags = '0;
    b2.frag_fifo_free = 16'h1010;
    repeat (3) cyc();
    resetn = 1'b1;
    m_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", b2.busy, 0);
    chk("rst_done", b2.done, 0);
    chk("rst_rd_en", b2.mem_rd_en, 0);
    chk("rst_wr_en", b2.frag_fifo_wr_en, 0);
    cyc();
    b1.start = 1'b1;
    mr = '0; mw = '0; ml = '0; md = '0;
    rd_q.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      mr[c] = b1.mem_rd_en; mw[c] = b1.frag_fifo_wr_en[0]; ml[c] = b1.frag_fifo_wr_last; md[c] = b1.done;
      if (b1.mem_rd_en) rd_q.push_back(b1.mem_rd_addr);
      cyc();
      b1.start = 1'b0;
    end
    chk("p1_rd_cycles", mr, 14'b00011110111100);
    chk("p1_push_cycles", mw, 14'b00111101111000);
    chk("p1_last_cycles", ml, 14'b00100001000000);
    chk("p1_done_cycle", md, 14'b01000000000000);
    chk("p1_nreads", rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++) chk("p1_addr", rd_q[i], 32'h100 + 32'(i));
    rd_q.delete(); last_q.delete();
    go(32'h40, 4'd1, 16'd3);
    wait_done(0);
    chk("rr_nfrags", last_q.size(), 3);
    if (last_q.size() == 3) begin
      chk("rr_f0", last_q[0], 2'b01);
      chk("rr_f1", last_q[1], 2'b10);
      chk("rr_f2", last_q[2], 2'b01);
    end
    go(32'h80, 4'd1, 16'd1);
    wait_done(0);
    last_q.delete();
    b2.frag_fifo_free = 16'h0802;
    go(32'h300, 4'd3, 16'd1);
    wait_done(0);
    chk("skip_nfrags", last_q.size(), 1);
    if (last_q.size() == 1) chk("skip_pipe", last_q[0], 2'b10);
    last_q.delete();
    b2.frag_fifo_free = 16'h0202;
    go(32'h500, 4'd3, 16'd1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(b2.mem_rd_en);
    end
    chk("stall_reads", n, 0);
    cyc();
    b2.frag_fifo_free = 16'h0204;
    @(negedge clk);
    chk("stall_sel_cycle", b2.mem_rd_en, 0);
    @(negedge clk);
    chk("stall_resume", b2.mem_rd_en, 1);
    wait_done(0);
    chk("stall_pipe", last_q.size() == 1 ? last_q[0] : 2'b11, 2'b01);
    b2.frag_fifo_free = 16'h1010;
    b2.num_frags = 16'd0; b2.start = 1'b1;
    @(negedge clk);
    chk("zero_done_start_cycle", b2.done, 0);
    cyc();
    b2.start = 1'b0;
    @(negedge clk);
    chk("zero_done", b2.done, 1);
    cyc();
    rd_q.delete();
    go(32'h2000, 4'd7, 16'd2);
    repeat (3) cyc();
    b2.f_array_ptr = 32'h9000; b2.num_frags = 16'd5; b2.start = 1'b1;
    cyc();
    b2.start = 1'b0;
    b2.en = 1'b0;
    repeat (3) cyc();
    b2.en = 1'b1;
    wait_done(0);
    chk("pause_nreads", rd_q.size(), 16);
    if (rd_q.size() == 16) chk("pause_last_addr", rd_q[15], 32'h200F);
    rd_q.delete();
    go(32'hFFFFFFFE, 4'd3, 16'd1);
    wait_done(0);
    chk("wrap_nreads", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      chk("wrap_a0", rd_q[0], 32'hFFFFFFFE);
      chk("wrap_a1", rd_q[1], 32'hFFFFFFFF);
      chk("wrap_a2", rd_q[2], 32'h00000000);
      chk("wrap_a3", rd_q[3], 32'h00000001);
    end
    go(32'h700, 4'd7, 16'd1);
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_mid_rd_en", b2.mem_rd_en, 0);
    chk("rst_mid_wr_en", b2.frag_fifo_wr_en, 0);
    chk("rst_mid_busy", b2.busy, 0);
    chk("rst_mid_last", b2.frag_fifo_wr_last, 0);
    cyc();
    resetn = 1'b1;
    cyc();
    for (int j = 0; j < 40; j++) begin
      b2.frag_fifo_free = {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
      go($urandom, 4'($urandom), 16'($urandom_range(0, 4)));
      wait_done(1);
    end
    repeat (2) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frag_rd_arbiter.md
Name: frag_rd_arbiter

Overview:
- Reader counterpart of the fragment write path. Fragments are packed in main memory at f_array_ptr, each vertexSize+1 words long.
- On start, the block fetches num_frags whole fragments in order over a 1-cycle-latency memory read port.
- Each fragment goes whole into one of NUM_F_PIPES downstream fragment FIFOs. Pipes are chosen round-robin, and a pipe without room for a full fragment is skipped.

Parameters:
NUM_F_PIPES, 2, number of downstream fragment FIFOs
DATA_WIDTH, 32, memory/FIFO word width
MAIN_MEM_ADDR_WIDTH, 32, main memory address width
LOCAL_VERTEX_MEM_ADDR_WIDTH, 4, width of vertexSize
FREE_W, 8, width of each FIFO free-slot count
FRAG_CNT_W, 16, width of num_frags

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, synchronous, active-low
en  in  1  global enable; gates read issue and state advance
start  in  1  one-cycle pulse, begin a fetch job
f_array_ptr  in  MAIN_MEM_ADDR_WIDTH  fragment array base address
vertexSize  in  LOCAL_VERTEX_MEM_ADDR_WIDTH  words per fragment minus 1
num_frags  in  FRAG_CNT_W  fragments to fetch
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  MAIN_MEM_ADDR_WIDTH  read address
mem_rd_data  in  DATA_WIDTH  valid exactly 1 cycle after mem_rd_en
frag_fifo_free  in  NUM_F_PIPES*FREE_W  free slots per FIFO
frag_fifo_wr_en  out  NUM_F_PIPES  one-hot push strobe
frag_fifo_wr_data  out  DATA_WIDTH  shared push data
frag_fifo_wr_last  out  1  marks last word of a fragment
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete

Behaviour:
- Reset (synchronous, resetn low at posedge): state IDLE; all outputs 0; rr_ptr=0; counters 0. Reset mid-job aborts the job; an in-flight read return is discarded (no wr_en after reset edge).
- States: IDLE, SELECT, READ, FINISH.
- IDLE:
  - start with en=1 latches f_array_ptr, vertexSize (vsz) and num_frags; base=f_array_ptr; busy=1.
  - Then go to SELECT, or to FINISH if num_frags==0.
  - start is ignored in all other states.
- SELECT:
  - Scan pipes from rr_ptr upward, modulo NUM_F_PIPES.
  - Take the first pipe with free >= vsz+1, compared at FREE_W width after zero-extending vsz+1. Latch it as sel, set offs=0, go to READ.
  - If no pipe qualifies, stay in SELECT with no reads issued.
- READ:
  - Every cycle with en=1: mem_rd_en=1, mem_rd_addr=base+offs (modulo 2^MAIN_MEM_ADDR_WIDTH), offs++.
  - When offs==vsz is issued:
    - base += vsz+1; frags_left--; rr_ptr=(sel+1) mod NUM_F_PIPES.
    - Next state is SELECT if frags_left is still nonzero after the decrement, else FINISH.
  - en=0: mem_rd_en=0, offs/state hold.
- Return path, independent of en:
  - One cycle after each mem_rd_en: frag_fifo_wr_en[sel_d]=1, frag_fifo_wr_data=mem_rd_data, frag_fifo_wr_last=(offs_d==vsz). sel_d and offs_d are the sel/offs registered with the issue.
- Throughput:
  - SELECT costs 1 cycle per fragment, so steady state is vsz+1 reads per vsz+2 cycles.
  - Free-count check is done once per fragment. The block never writes more words than free showed at selection; the downstream must not shrink free except through these writes.
- FINISH: waits for the final return push, then done=1 for 1 cycle, busy=0, and returns to IDLE in the same cycle. For num_frags==0, done occurs the cycle after start.
- Fragment order in memory is preserved, and no fragment is ever split across pipes.

Test Plan:
- NUM_F_PIPES=1, ptr=0x100, vsz=3, num_frags=2, free=16 -> reads 0x100–0x103, SELECT gap, then 0x104–0x107. Eight pushes to pipe0, each 1 cycle after its read; last on the 4th and 8th push; done 1 cycle after the 8th push.
- 2 pipes, free=16 both, 3 frags, vsz=1 -> fragments go to pipes 0,1,0; wr_en is one-hot throughout.
- 2 pipes, vsz=3, free0=2, free1=8 -> pipe0 is skipped and fragment goes to pipe1. With both free=2: no mem_rd_en. Raising free0 to 4 -> reads start the cycle after the next SELECT evaluation.
- num_frags=0 -> done pulse the cycle after start, no reads. A second start while busy is ignored.
- en low for 3 cycles mid-fragment -> reads pause and resume at the same addr, with no duplicate or missing pushes. Reset asserted mid-READ -> all outputs 0 at the next edge, and no push from the in-flight read.
- ptr=0xFFFFFFFE, vsz=3 -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
